gfp_alu: RTL and testbench



---
 rtl/gfp_pkg.sv | 24 ++
 rtl/gfp_addsub_mod.sv | 36 +++
 rtl/gfp_alu.sv | 220 ++++++++++++++++++++++
 tb/tb_gfp_alu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfp_pkg.sv
// gfp_pkg: shared definitions for the GF(p) arithmetic unit.
//   - op encodings presented on i_op
//   - FSM state type used by gfp_alu
//   - watchdog limit for the binary extended Euclid divider
package gfp_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Iteration budget for the divider; binary extended Euclid on coprime
  // inputs always converges well inside 4*WIDTH steps.
  function automatic int wd_limit(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/gfp_addsub_mod.sv
// gfp_addsub_mod: combinational (a +/- b) mod p with one conditional
// correction. Both operands must already be reduced (< p).
//   a, b  : operands, WIDTH bits
//   p     : odd modulus, WIDTH bits
//   sub   : 0 = a+b, 1 = a-b
//   y     : reduced result, WIDTH bits
module gfp_addsub_mod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum_ext;
  logic           borrow;
  logic           add_over;

  always_comb begin
    // The carry-out of a+b is needed for the compare against p; the
    // corrected values themselves are formed at WIDTH bits because the
    // modular wrap of the truncated arithmetic lands on the right answer.
    sum_ext  = {1'b0, a} + {1'b0, b};
    borrow   = (a < b);
    add_over = (sum_ext >= {1'b0, p});
    y        = '0;
    if (sub) begin
      y = borrow ? (a - b + p) : (a - b);
    end else begin
      y = add_over ? (a + b - p) : (a + b);
    end
  end

endmodule

// File: rtl/gfp_alu.sv
// gfp_alu: GF(p) arithmetic unit (add, sub, multiply, divide).
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_start   : operation request, sampled while o_busy=0
//   i_op      : 0=ADD 1=SUB 2=MUL 3=DIV
//   i_a, i_b  : operands (< p)
//   i_prime   : odd modulus p > 2
//   o_busy    : multi-cycle operation in progress
//   o_done    : one-cycle completion pulse
//   o_result  : result, held until the next completion
//   o_err     : qualifies o_done; divide by zero / non-invertible divisor
module gfp_alu
  import gfp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_prime,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  localparam int LIMIT = wd_limit(WIDTH);
  localparam int CW    = $clog2(LIMIT + 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;     // MUL: multiplier, shifted left one bit per cycle
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] u_reg;
  logic [WIDTH-1:0] v_reg;
  logic [WIDTH-1:0] x1_reg;
  logic [WIDTH-1:0] x2_reg;
  logic [CW-1:0]    cnt_reg;

  // Shared add/sub unit: ADD/SUB from IDLE, doubling in MUL, x1/x2 update in DIV.
  logic [WIDTH-1:0] as0_a, as0_b, as0_p, as0_y;
  logic             as0_sub;
  // Second unit: the conditional "+a" step of MUL, chained after the doubling.
  logic [WIDTH-1:0] as1_y;
  logic [WIDTH-1:0] mul_next;

  always_comb begin
    as0_a   = i_a;
    as0_b   = i_b;
    as0_p   = i_prime;
    as0_sub = (i_op == OP_SUB);
    case (state_reg)
      ST_MUL: begin
        as0_a   = acc_reg;
        as0_b   = acc_reg;
        as0_p   = p_reg;
        as0_sub = 1'b0;
      end
      ST_DIV: begin
        as0_p   = p_reg;
        as0_sub = 1'b1;
        if (u_reg >= v_reg) begin
          as0_a = x1_reg;
          as0_b = x2_reg;
        end else begin
          as0_a = x2_reg;
          as0_b = x1_reg;
        end
      end
      default: ;
    endcase
  end

  gfp_addsub_mod #(.WIDTH(WIDTH)) u_as0 (
    .a   (as0_a),
    .b   (as0_b),
    .p   (as0_p),
    .sub (as0_sub),
    .y   (as0_y)
  );

  gfp_addsub_mod #(.WIDTH(WIDTH)) u_as1 (
    .a   (as0_y),
    .b   (a_reg),
    .p   (p_reg),
    .sub (1'b0),
    .y   (as1_y)
  );

  assign mul_next = b_reg[WIDTH-1] ? as1_y : as0_y;

  // x/2 mod p for odd p: an odd x becomes (x+p)/2, rewritten as
  // (x>>1)+(p>>1)+1 so it never needs a WIDTH+1 bit intermediate.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    if (x[0]) return (x >> 1) + (p >> 1) + 1'b1;
    else      return x >> 1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      acc_reg   <= '0;
      u_reg     <= '0;
      v_reg     <= '0;
      x1_reg    <= '0;
      x2_reg    <= '0;
      cnt_reg   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_result  <= '0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_ADD, OP_SUB: begin
                o_result <= as0_y;
                o_err    <= 1'b0;
                o_done   <= 1'b1;
              end
              OP_MUL: begin
                a_reg     <= i_a;
                b_reg     <= i_b;
                p_reg     <= i_prime;
                acc_reg   <= '0;
                cnt_reg   <= CW'(WIDTH - 1);
                o_busy    <= 1'b1;
                state_reg <= ST_MUL;
              end
              default: begin
                if (i_b == '0) begin
                  o_result <= '0;
                  o_err    <= 1'b1;
                  o_done   <= 1'b1;
                end else begin
                  u_reg     <= i_b;
                  v_reg     <= i_prime;
                  x1_reg    <= i_a;
                  x2_reg    <= '0;
                  p_reg     <= i_prime;
                  cnt_reg   <= '0;
                  o_busy    <= 1'b1;
                  state_reg <= ST_DIV;
                end
              end
            endcase
          end
        end

        ST_MUL: begin
          acc_reg <= mul_next;
          b_reg   <= b_reg << 1;
          if (cnt_reg == '0) begin
            o_result  <= mul_next;
            o_err     <= 1'b0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_DIV: begin
          if (u_reg == WIDTH'(1)) begin
            o_result  <= x1_reg;
            o_err     <= 1'b0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (v_reg == WIDTH'(1)) begin
            o_result  <= x2_reg;
            o_err     <= 1'b0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CW'(LIMIT - 1)) begin
            // Out of iterations: divisor shares a factor with p.
            o_result  <= '0;
            o_err     <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (!u_reg[0]) begin
              u_reg  <= u_reg >> 1;
              x1_reg <= half_mod(x1_reg, p_reg);
            end else if (!v_reg[0]) begin
              v_reg  <= v_reg >> 1;
              x2_reg <= half_mod(x2_reg, p_reg);
            end else if (u_reg >= v_reg) begin
              u_reg  <= u_reg - v_reg;
              x1_reg <= as0_y;
            end else begin
              v_reg  <= v_reg - u_reg;
              x2_reg <= as0_y;
            end
          end
        end

        default: begin
          o_busy    <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfp_alu.sv
module tb_gfp_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [1:0] op8 = 2'd0;
  logic [7:0] a8 = '0, b8 = '0, p8 = '0;
  logic       busy8, done8, err8;
  logic [7:0] result8;

  // 32-bit instance
  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'd0;
  logic [31:0] a32 = '0, b32 = '0, p32 = '0;
  logic        busy32, done32, err32;
  logic [31:0] result32;

  int errors = 0;
  int checks = 0;

  gfp_alu #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_op(op8),
    .i_a(a8), .i_b(b8), .i_prime(p8),
    .o_busy(busy8), .o_done(done8), .o_result(result8), .o_err(err8)
  );

  gfp_alu #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_op(op32),
    .i_a(a32), .i_b(b32), .i_prime(p32),
    .o_busy(busy32), .o_done(done32), .o_result(result32), .o_err(err32)
  );

  // Issue one op on the 8-bit DUT and wait for o_done. Latency counts edges
  // from the accept edge (inclusive) to the edge after which o_done=1.
  // Called at posedge+1 with the DUT idle. lat=-1 on timeout.
  task automatic run8(input logic [1:0] op, input logic [7:0] a, b, p,
                      output logic [7:0] res, output logic err,
                      output int lat, output int busy_n);
    op8 = op; a8 = a; b8 = b; p8 = p; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; busy_n = 0;
    while (!done8 && lat < 300) begin
      if (busy8) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done8) lat = -1;
    res = result8; err = err8;
  endtask

  task automatic run32(input logic [1:0] op, input logic [31:0] a, b, p,
                       output logic [31:0] res, output logic err,
                       output int lat);
    op32 = op; a32 = a; b32 = b; p32 = p; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done32) lat = -1;
    res = result32; err = err32;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, err8, result8} !== 11'd0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b err=%b res=%0d required all 0", busy8, done8, err8, result8);
    end
    checks++;
    if ({busy32, done32, err32, result32} !== 35'd0) begin
      errors++; $display("FAIL reset32 got busy=%b done=%b err=%b res=%0d required all 0", busy32, done32, err32, result32);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: outputs zero after reset");
  endtask

  task automatic test_add_sub();
    logic [7:0] r; logic e; int lat, bn;
    run8(2'd0, 8'd200, 8'd100, 8'd251, r, e, lat, bn);
    $display("ADD 200+100 mod 251 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd49 || e !== 1'b0) begin
      errors++; $display("FAIL add_result got %0d err=%b required 49 err=0", r, e);
    end
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL add_latency got %0d required 1", lat);
    end
    @(posedge clk); #1;
    run8(2'd1, 8'd5, 8'd10, 8'd251, r, e, lat, bn);
    $display("SUB 5-10 mod 251 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd246 || e !== 1'b0 || lat != 1) begin
      errors++; $display("FAIL sub got %0d err=%b lat=%0d required 246 err=0 lat=1", r, e, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [7:0] r; logic e; int lat, bn;
    logic [31:0] r32; logic e32; int lat32;
    run8(2'd2, 8'd17, 8'd15, 8'd251, r, e, lat, bn);
    $display("MUL 17*15 mod 251 -> %0d err=%b lat=%0d busy=%0d", r, e, lat, bn);
    checks++;
    if (r !== 8'd4 || e !== 1'b0) begin
      errors++; $display("FAIL mul8_result got %0d err=%b required 4 err=0", r, e);
    end
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL mul8_latency got %0d required 9", lat);
    end
    checks++;
    if (bn != 8) begin
      errors++; $display("FAIL mul8_busy_cycles got %0d required 8", bn);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL mul8_busy_in_done got %b required 0", busy8);
    end
    @(posedge clk); #1;
    run32(2'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, r32, e32, lat32);
    $display("MUL32 (p-1)*(p-1) -> %0d err=%b lat=%0d", r32, e32, lat32);
    checks++;
    if (r32 !== 32'd1 || e32 !== 1'b0 || lat32 != 33) begin
      errors++; $display("FAIL mul32 got %0d err=%b lat=%0d required 1 err=0 lat=33", r32, e32, lat32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    logic [7:0] r; logic e; int lat, bn;
    run8(2'd3, 8'd1, 8'd2, 8'd251, r, e, lat, bn);
    $display("DIV 1/2 mod 251 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd126 || e !== 1'b0 || lat != 3) begin
      errors++; $display("FAIL div_1_2 got %0d err=%b lat=%0d required 126 err=0 lat=3", r, e, lat);
    end
    @(posedge clk); #1;
    run8(2'd3, 8'd7, 8'd7, 8'd251, r, e, lat, bn);
    $display("DIV 7/7 mod 251 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd1 || e !== 1'b0 || lat < 2 || lat > 33) begin
      errors++; $display("FAIL div_7_7 got %0d err=%b lat=%0d required 1 err=0 lat in 2..33", r, e, lat);
    end
    @(posedge clk); #1;
    run8(2'd3, 8'd3, 8'd5, 8'd251, r, e, lat, bn);
    $display("DIV 3/5 mod 251 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd101 || e !== 1'b0 || lat < 2 || lat > 33) begin
      errors++; $display("FAIL div_3_5 got %0d err=%b lat=%0d required 101 err=0 lat in 2..33", r, e, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_err();
    logic [7:0] r; logic e; int lat, bn;
    run8(2'd3, 8'd9, 8'd0, 8'd251, r, e, lat, bn);
    $display("DIV 9/0 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd0 || e !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL div_zero got %0d err=%b lat=%0d required 0 err=1 lat=1", r, e, lat);
    end
    @(posedge clk); #1;
    run8(2'd3, 8'd1, 8'd3, 8'd15, r, e, lat, bn);
    $display("DIV 1/3 mod 15 -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd0 || e !== 1'b1 || lat != 33) begin
      errors++; $display("FAIL div_watchdog got %0d err=%b lat=%0d required 0 err=1 lat=33", r, e, lat);
    end
    @(posedge clk); #1;
    run8(2'd0, 8'd1, 8'd2, 8'd251, r, e, lat, bn);
    $display("ADD 1+2 after error -> %0d err=%b", r, e);
    checks++;
    if (r !== 8'd3 || e !== 1'b0) begin
      errors++; $display("FAIL err_clear got %0d err=%b required 3 err=0", r, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int lat;
    op8 = 2'd2; a8 = 8'd17; b8 = 8'd15; p8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    op8 = 2'd0; a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1; lat++;
    start8 = 1'b0;
    while (!done8 && lat < 300) begin @(posedge clk); #1; lat++; end
    $display("MUL with stray start -> %0d lat=%0d", result8, lat);
    checks++;
    if (result8 !== 8'd4 || lat != 9) begin
      errors++; $display("FAIL start_ignored got %0d lat=%0d required 4 lat=9", result8, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin
      errors++; $display("FAIL no_queued_op got done=%b required 0", done8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    op8 = 2'd0; a8 = 8'd200; b8 = 8'd100; p8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1;
    $display("b2b first: done=%b res=%0d", done8, result8);
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'd49) begin
      errors++; $display("FAIL b2b_first got done=%b res=%0d required done=1 res=49", done8, result8);
    end
    a8 = 8'd1; b8 = 8'd2;
    @(posedge clk); #1;
    start8 = 1'b0;
    $display("b2b second: done=%b res=%0d", done8, result8);
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'd3) begin
      errors++; $display("FAIL b2b_second got done=%b res=%0d required done=1 res=3", done8, result8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || result8 !== 8'd3) begin
      errors++; $display("FAIL b2b_hold got done=%b res=%0d required done=0 res=3", done8, result8);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] r; logic e; int lat, bn;
    bit saw_done;
    op8 = 2'd3; a8 = 8'd7; b8 = 8'd7; p8 = 8'd251; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++; $display("FAIL div_busy_pre_reset got %b required 1", busy8);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-DIV: busy=%b done=%b err=%b res=%0d", busy8, done8, err8, result8);
    checks++;
    if ({busy8, done8, err8, result8} !== 11'd0) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b err=%b res=%0d required all 0", busy8, done8, err8, result8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL aborted_op got done/busy activity required none");
    end
    run8(2'd0, 8'd200, 8'd100, 8'd251, r, e, lat, bn);
    $display("ADD after reset -> %0d err=%b lat=%0d", r, e, lat);
    checks++;
    if (r !== 8'd49 || e !== 1'b0 || lat != 1) begin
      errors++; $display("FAIL add_after_reset got %0d err=%b lat=%0d required 49 err=0 lat=1", r, e, lat);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_div_err();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
